uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
- UART receive front end; sits directly downstream of the baud/sample clock generator.
- Consumes the generator's 16x oversampling clock (smp_clk) as a level signal. Runs entirely in the sys_clk domain, with no logic clocked by smp_clk.
- Deserialises 8N1 frames from the asynchronous rx line, majority-votes each bit, and presents bytes to the single-cycle CPU's I/O logic as a one-cycle valid pulse.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- OVERSAMPLE, 16, sample ticks per bit period; must be even and ≥ 8.

Ports:
- sys_clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- smp_clk  input  1  oversampling clock level from the generator; each high and low phase ≥ 2 sys_clk cycles.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last correctly received byte.
- rx_valid  output  1  one-sys_clk pulse when rx_data is updated.
- frame_err  output  1  one-sys_clk pulse on a stop-bit error.
- busy  output  1  high while a frame is being received (any state except IDLE).

Behaviour:
- Reset (reset=0, async):
  - rx_data=0, rx_valid=0, frame_err=0, busy=0.
  - FSM to IDLE; sample counter and bit counter to 0.
  - rx synchroniser flops to 1; smp_clk synchroniser flops to 0.
- Synchronisers:
  - rx and smp_clk each pass through 2 flops.
  - tick = rising edge of synchronised smp_clk (one sys_clk pulse per smp_clk period).
- All FSM, counter and vote updates occur only on sys_clk edges where tick=1. rx_valid and frame_err are cleared on every other cycle.
- scnt: sample index 0..OVERSAMPLE-1 within the current bit; wraps to 0 at OVERSAMPLE-1.
- Vote: samples at scnt = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 (7, 8, 9 by default). Bit value = majority of the 3.
- States:
  - IDLE: a tick with rx_s=0 enters START with scnt=1; the detecting tick counts as sample 0.
  - START:
    - At scnt=OVERSAMPLE/2+1, if the vote is 1 → IDLE (glitch rejected; no output, no flags).
    - Otherwise, at scnt=OVERSAMPLE-1 → DATA with bitcnt=0, scnt=0.
  - DATA:
    - At scnt=OVERSAMPLE-1, the voted bit shifts into the MSB of the shift register (LSB-first line order) and bitcnt increments.
    - When bitcnt reaches DATA_BITS-1 and that bit completes → STOP.
  - STOP: decision at scnt=OVERSAMPLE/2+1 (mid stop bit).
    - Vote 1: rx_data ← shift register, rx_valid=1 for exactly one sys_clk cycle → IDLE.
    - Vote 0: frame_err=1 for one cycle, rx_data unchanged → BREAK.
  - BREAK: stays until a tick sees rx_s=1, then → IDLE. This prevents a held-low line from retriggering frames.
- Latency: rx_valid rises 1 sys_clk after the tick carrying stop sample OVERSAMPLE/2+1. With the generator defaults (650 sys_clk per tick) this is ≈ 9.6 bit times after the falling start edge.
- Back-to-back frames: returning to IDLE at mid-stop allows a start edge arriving as early as the next tick to be accepted.
- rx_data holds its value until the next good frame. There is no consumer handshake; the consumer must capture it on rx_valid.
- Reset asserted mid-frame aborts immediately with no output pulse. After release, the block waits in IDLE for a fresh start edge.
- smp_clk stopped: the FSM freezes in its current state (no timeout).

Test Plan:
- Drive smp_clk with period 8 sys_clk and send 8N1 byte 0xA5 at 16 ticks/bit → exactly one rx_valid pulse, rx_data=0xA5, frame_err never 1.
- Pull rx low for 3 ticks, then high → busy rises, then returns to 0 by tick 9. No rx_valid, no frame_err, rx_data unchanged.
- Receive 0x3C, then send 0xC3 with the stop bit low → frame_err pulses once, rx_data remains 0x3C, and the FSM stays in BREAK until rx returns high.
- Send back-to-back 0x00 and 0xFF with no idle gap → two rx_valid pulses, data 0x00 then 0xFF.
- Hold rx low for 30 bit times, then release and send 0x55 → one frame_err, then rx_data=0x55 with one rx_valid.
- Assert reset during data bit 4 of 0x81, release, then send 0x7E → no output for the aborted frame; rx_data=0x7E afterwards.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver driven by a 16x oversampling tick, majority-voted bits
module uart_rx_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 smp_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SC_V0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SC_V1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SC_V2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t               state_q;
    logic [SW-1:0]        scnt_q;
    logic [BW-1:0]        bcnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic                 smp_meta_q;
    logic                 smp_s_q;
    logic                 smp_prev_q;
    logic                 smp0_q;
    logic                 smp1_q;
    logic                 bit_q;
    logic                 tick;
    logic                 vote;
    logic [SW-1:0]        scnt_inc;

    // The third vote sample is the live synchronised line at the tick that closes the window.
    assign tick     = smp_s_q & ~smp_prev_q;
    assign vote     = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
    assign scnt_inc = scnt_q + 1'b1;
    assign shreg_d  = {bit_q, shreg_q[DATA_BITS-1:1]};

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = state_q != S_IDLE;

    // Two-flop synchronisers for rx (idles high) and smp_clk, plus smp_clk edge history.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            smp_meta_q <= 1'b0;
            smp_s_q    <= 1'b0;
            smp_prev_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            smp_meta_q <= smp_clk;
            smp_s_q    <= smp_meta_q;
            smp_prev_q <= smp_s_q;
        end
    end

    // Frame FSM: advances only on ticks; output pulses self-clear on every other cycle.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            scnt_q      <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            smp0_q      <= 1'b1;
            smp1_q      <= 1'b1;
            bit_q       <= 1'b1;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (tick) begin
                if (scnt_q == SC_V0) smp0_q <= rx_s_q;
                if (scnt_q == SC_V1) smp1_q <= rx_s_q;
                if (scnt_q == SC_V2) bit_q <= vote;
                case (state_q)
                    S_IDLE: begin
                        if (!rx_s_q) begin
                            state_q <= S_START;
                            scnt_q  <= SW'(1);
                        end
                    end
                    S_START: begin
                        if (scnt_q == SC_V2 && vote) begin
                            state_q <= S_IDLE;
                            scnt_q  <= '0;
                        end else if (scnt_q == SC_LAST) begin
                            state_q <= S_DATA;
                            scnt_q  <= '0;
                            bcnt_q  <= '0;
                        end else begin
                            scnt_q <= scnt_inc;
                        end
                    end
                    S_DATA: begin
                        scnt_q <= scnt_q == SC_LAST ? '0 : scnt_inc;
                        if (scnt_q == SC_LAST) begin
                            shreg_q <= shreg_d;
                            bcnt_q  <= bcnt_q + 1'b1;
                            if (bcnt_q == BC_LAST) state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        scnt_q <= scnt_q == SC_V2 ? '0 : scnt_inc;
                        if (scnt_q == SC_V2) begin
                            if (vote) begin
                                rx_data_q  <= shreg_q;
                                rx_valid_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= S_BREAK;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (rx_s_q) state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        scnt_q  <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed frame table plus corner-case sequences for uart_rx_sampler
module tb_uart_rx_sampler;
    localparam int BIT = 128;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b0;
    logic       smp_clk = 1'b0;
    logic       rx      = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int         tests = 0;
    int         fails = 0;
    int         n_valid = 0;
    int         n_err = 0;
    logic [7:0] log_q[$];

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         dv;
        int         de;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[6];

    uart_rx_sampler dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .smp_clk  (smp_clk),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial forever begin
        repeat (4) @(posedge sys_clk);
        smp_clk = ~smp_clk;
    end

    always @(negedge sys_clk) begin
        if (rx_valid) begin
            n_valid++;
            log_q.push_back(rx_data);
        end
        if (frame_err) n_err++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    initial begin
        int         v0;
        int         e0;
        int         n0;
        int         seen;
        logic [7:0] d0;

        vt[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vt[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
        vt[2] = '{8'hC3, 1'b0, 0, 1, 8'h3C};
        vt[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vt[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vt[5] = '{8'h81, 1'b1, 1, 0, 8'h81};

        repeat (5) @(negedge sys_clk);
        check("reset rx_data", int'(rx_data), 0);
        check("reset rx_valid", int'(rx_valid), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset busy", int'(busy), 0);
        reset = 1'b1;
        idle(2);

        for (int k = 0; k < 6; k++) begin
            v0 = n_valid;
            e0 = n_err;
            send_byte(vt[k].d, vt[k].stop);
            idle(2);
            check($sformatf("vec%0d valid count", k), n_valid - v0, vt[k].dv);
            check($sformatf("vec%0d err count", k), n_err - e0, vt[k].de);
            check($sformatf("vec%0d rx_data", k), int'(rx_data), int'(vt[k].exp));
            check($sformatf("vec%0d busy", k), int'(busy), 0);
        end

        // start-bit glitch of 3 ticks
        v0 = n_valid;
        e0 = n_err;
        d0 = rx_data;
        seen = 0;
        rx = 1'b0;
        repeat (24) begin
            @(negedge sys_clk);
            if (busy) seen = 1;
        end
        rx = 1'b1;
        repeat (16) begin
            @(negedge sys_clk);
            if (busy) seen = 1;
        end
        check("glitch busy rose", seen, 1);
        repeat (60) @(negedge sys_clk);
        check("glitch busy cleared", int'(busy), 0);
        idle(2);
        check("glitch valid count", n_valid - v0, 0);
        check("glitch err count", n_err - e0, 0);
        check("glitch rx_data", int'(rx_data), int'(d0));

        // stop-bit error held low stays in BREAK
        v0 = n_valid;
        e0 = n_err;
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check("break busy held", int'(busy), 1);
        check("break err count", n_err - e0, 1);
        check("break valid count", n_valid - v0, 1);
        check("break rx_data", int'(rx_data), 8'h3C);
        idle(2);
        check("break exit busy", int'(busy), 0);

        // back-to-back frames with no idle gap
        n0 = log_q.size();
        v0 = n_valid;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(2);
        check("b2b valid count", n_valid - v0, 2);
        check("b2b first", log_q.size() > n0 ? int'(log_q[n0]) : -1, 8'h00);
        check("b2b second", log_q.size() > n0 + 1 ? int'(log_q[n0 + 1]) : -1, 8'hFF);

        // line held low for 30 bit times
        v0 = n_valid;
        e0 = n_err;
        rx = 1'b0;
        repeat (30 * BIT) @(negedge sys_clk);
        idle(2);
        check("long low err count", n_err - e0, 1);
        check("long low valid count", n_valid - v0, 0);
        check("long low busy", int'(busy), 0);
        send_byte(8'h55, 1'b1);
        idle(2);
        check("after long low valid", n_valid - v0, 1);
        check("after long low data", int'(rx_data), 8'h55);
        check("after long low err", n_err - e0, 1);

        // reset during data bit 4 of 0x81
        v0 = n_valid;
        e0 = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        rx = 1'b0;
        repeat (BIT / 2) @(negedge sys_clk);
        check("pre-abort busy", int'(busy), 1);
        reset = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("abort busy", int'(busy), 0);
        check("abort rx_data", int'(rx_data), 0);
        reset = 1'b1;
        idle(3);
        check("abort valid count", n_valid - v0, 0);
        check("abort err count", n_err - e0, 0);
        send_byte(8'h7E, 1'b1);
        idle(2);
        check("post-abort valid", n_valid - v0, 1);
        check("post-abort data", int'(rx_data), 8'h7E);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
